// File: rtl/pong_referee.sv
// pong_referee: per-frame ball/paddle judge. Watches each side's guard row
// during a frame, decides hit or miss on the next frame start, keeps score,
// detects the match win and holds the playfield in reset for a fixed number
// of frames after every miss.
module pong_referee #(
  parameter int VRES          = 720,
  parameter int PADDLE_H      = 20,
  parameter int TWO_SIDED     = 1,
  parameter int RESTART_PAUSE = 128,
  parameter int PAUSE_W       = 8,
  parameter int WIN_SCORE     = 7,
  parameter int SCORE_W       = 4
) (
  input  logic                pixel_clk,
  input  logic                rst_n,
  input  logic                fsync,
  input  logic signed [11:0]  vpos,
  input  logic                active_obj,
  input  logic [1:0]          active_paddle,
  input  logic                restart,
  output logic                obj_rst,
  output logic                game_over,
  output logic                match_over,
  output logic [SCORE_W-1:0]  score_p1,
  output logic [SCORE_W-1:0]  score_p2,
  output logic                point_p1,
  output logic                point_p2,
  output logic [PAUSE_W-1:0]  pause_cnt
);

  typedef enum logic [1:0] {
    S_WAIT       = 2'd0,
    S_SCAN       = 2'd1,
    S_PAUSE      = 2'd2,
    S_MATCH_OVER = 2'd3
  } state_t;

  // In single-sided play both paddles defend the bottom row.
  localparam logic signed [11:0] ROW_P1 = 12'(VRES - PADDLE_H);
  localparam logic signed [11:0] ROW_P2 = (TWO_SIDED != 0) ? 12'(PADDLE_H - 1) : ROW_P1;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(RESTART_PAUSE - 1);

  state_t               state, state_next;
  logic [1:0]           hit, hit_next;
  logic [1:0]           pass, pass_next;
  logic [1:0]           on_row, covered, px_hit, px_pass, miss;
  logic [SCORE_W-1:0]   score_p1_next, score_p2_next;
  logic                 point_p1_next, point_p2_next;
  logic [PAUSE_W-1:0]   pause_cnt_next;
  logic                 overlay_next, match_over_next;

  // Scores stick at the counter maximum instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  // Classify the current pixel against each side's guard row.
  always_comb begin
    on_row[0] = active_obj && (vpos == ROW_P1);
    on_row[1] = active_obj && (vpos == ROW_P2);
    // Single-sided: either paddle saves the ball for both sides.
    covered   = (TWO_SIDED != 0) ? active_paddle : {2{|active_paddle}};
    px_hit    = on_row & covered;
    px_pass   = on_row & ~covered;
    miss      = pass & ~hit;
  end

  // Next-state, frame judgement, scoring and registered-output decode.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves one unassigned and infers a latch.
    state_next     = state;
    hit_next       = hit;
    pass_next      = pass;
    score_p1_next  = score_p1;
    score_p2_next  = score_p2;
    point_p1_next  = 1'b0;
    point_p2_next  = 1'b0;
    pause_cnt_next = pause_cnt;

    case (state)
      S_WAIT: begin
        if (fsync) begin
          state_next = S_SCAN;
          hit_next   = px_hit;
          pass_next  = px_pass;
        end
      end

      S_SCAN: begin
        if (fsync) begin
          // Judge the finished frame; this cycle's pixel opens the next one.
          hit_next  = px_hit;
          pass_next = px_pass;
          if (miss != 2'b00) begin
            hit_next   = '0;
            pass_next  = '0;
            state_next = S_PAUSE;
            if (TWO_SIDED != 0 && miss == 2'b01) begin
              score_p2_next = sat_inc(score_p2);
              point_p2_next = 1'b1;
              if (score_p2_next == WIN) state_next = S_MATCH_OVER;
            end else if (TWO_SIDED != 0 && miss == 2'b10) begin
              score_p1_next = sat_inc(score_p1);
              point_p1_next = 1'b1;
              if (score_p1_next == WIN) state_next = S_MATCH_OVER;
            end
          end
        end else begin
          hit_next  = hit | px_hit;
          pass_next = pass | px_pass;
        end
      end

      S_PAUSE: begin
        if (fsync) begin
          if (pause_cnt == PAUSE_LAST) begin
            pause_cnt_next = '0;
            state_next     = S_WAIT;
          end else begin
            pause_cnt_next = pause_cnt + PAUSE_W'(1);
          end
        end
      end

      S_MATCH_OVER: begin
        if (restart) begin
          score_p1_next = '0;
          score_p2_next = '0;
          state_next    = S_WAIT;
        end
      end

      default: state_next = S_WAIT;
    endcase

    overlay_next    = (state_next == S_PAUSE) || (state_next == S_MATCH_OVER);
    match_over_next = (state_next == S_MATCH_OVER);
  end

  // State, per-frame flags and registered outputs.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT;
      hit        <= '0;
      pass       <= '0;
      obj_rst    <= 1'b0;
      game_over  <= 1'b0;
      match_over <= 1'b0;
      score_p1   <= '0;
      score_p2   <= '0;
      point_p1   <= 1'b0;
      point_p2   <= 1'b0;
      pause_cnt  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
      state      <= state_next;
      hit        <= hit_next;
      pass       <= pass_next;
      obj_rst    <= overlay_next;
      game_over  <= overlay_next;
      match_over <= match_over_next;
      score_p1   <= score_p1_next;
      score_p2   <= score_p2_next;
      point_p1   <= point_p1_next;
      point_p2   <= point_p2_next;
      pause_cnt  <= pause_cnt_next;
    end
  end

endmodule

// File: tb/tb_pong_referee.sv
// tb_pong_referee: drives a two-sided and a single-sided referee from the same
// pixel stream and compares every output, every cycle, against a frame-level
// model of the game rules.
module tb_pong_referee;

  localparam int VRES     = 720;
  localparam int PADDLE_H = 20;
  localparam int RP_TS    = 128;
  localparam int RP_SS    = 5;
  localparam int WIN      = 7;
  localparam int SW       = 4;
  localparam int PW       = 8;
  localparam int ROW_BOT  = VRES - PADDLE_H;
  localparam int ROW_TOP  = PADDLE_H - 1;

  logic               pixel_clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               fsync = 1'b0;
  logic signed [11:0] vpos = '0;
  logic               active_obj = 1'b0;
  logic [1:0]         active_paddle = '0;
  logic               restart = 1'b0;

  // Index 0: two-sided instance, index 1: single-sided instance.
  logic          obj_rst_o    [2];
  logic          game_over_o  [2];
  logic          match_over_o [2];
  logic [SW-1:0] score_p1_o   [2];
  logic [SW-1:0] score_p2_o   [2];
  logic          point_p1_o   [2];
  logic          point_p2_o   [2];
  logic [PW-1:0] pause_cnt_o  [2];

  int vectors = 0;
  int miscompares = 0;

  // Frame-level model: live/waiting flags, pause countdown, scores.
  bit m_over [2];
  bit m_wait [2];
  int m_left [2];
  int m_s1   [2];
  int m_s2   [2];
  bit m_pt1  [2];
  bit m_pt2  [2];
  bit m_hit  [2][2];
  bit m_pass [2][2];

  pong_referee #(
    .VRES(VRES), .PADDLE_H(PADDLE_H), .TWO_SIDED(1), .RESTART_PAUSE(RP_TS),
    .PAUSE_W(PW), .WIN_SCORE(WIN), .SCORE_W(SW)
  ) dut_ts (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .vpos(vpos),
    .active_obj(active_obj), .active_paddle(active_paddle), .restart(restart),
    .obj_rst(obj_rst_o[0]), .game_over(game_over_o[0]), .match_over(match_over_o[0]),
    .score_p1(score_p1_o[0]), .score_p2(score_p2_o[0]),
    .point_p1(point_p1_o[0]), .point_p2(point_p2_o[0]), .pause_cnt(pause_cnt_o[0])
  );

  pong_referee #(
    .VRES(VRES), .PADDLE_H(PADDLE_H), .TWO_SIDED(0), .RESTART_PAUSE(RP_SS),
    .PAUSE_W(PW), .WIN_SCORE(WIN), .SCORE_W(SW)
  ) dut_ss (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .fsync(fsync), .vpos(vpos),
    .active_obj(active_obj), .active_paddle(active_paddle), .restart(restart),
    .obj_rst(obj_rst_o[1]), .game_over(game_over_o[1]), .match_over(match_over_o[1]),
    .score_p1(score_p1_o[1]), .score_p2(score_p2_o[1]),
    .point_p1(point_p1_o[1]), .point_p2(point_p2_o[1]), .pause_cnt(pause_cnt_o[1])
  );

  always #5 pixel_clk = ~pixel_clk;

  function automatic int rp_of(input int m);
    return (m == 0) ? RP_TS : RP_SS;
  endfunction

  function automatic int row_of(input int m, input int s);
    if (m == 1) return ROW_BOT;
    return (s == 0) ? ROW_BOT : ROW_TOP;
  endfunction

  // Any line that is not a guard row, including a few blanking lines.
  function automatic int filler_v();
    int v;
    do v = int'($urandom_range(0, VRES + 29)) - 30;
    while (v == ROW_BOT || v == ROW_TOP);
    return v;
  endfunction

  function automatic int rand_v();
    case ($urandom_range(0, 3))
      0:       return ROW_BOT;
      1:       return ROW_TOP;
      default: return filler_v();
    endcase
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_over[m] = 0; m_wait[m] = 1; m_left[m] = 0;
      m_s1[m] = 0; m_s2[m] = 0; m_pt1[m] = 0; m_pt2[m] = 0;
      for (int s = 0; s < 2; s++) begin m_hit[m][s] = 0; m_pass[m][s] = 0; end
    end
  endtask

  task automatic model_pixel(input int m, input int v, input bit obj, input logic [1:0] pad);
    for (int s = 0; s < 2; s++) begin
      if (obj && v == row_of(m, s)) begin
        if ((m == 1) ? (pad != 2'b00) : pad[s]) m_hit[m][s] = 1;
        else                                    m_pass[m][s] = 1;
      end
    end
  endtask

  // Ball missed by side s gives the point to the other side.
  task automatic model_score(input int m, input int loser);
    if (loser == 0) begin
      if (m_s2[m] < (1 << SW) - 1) m_s2[m]++;
      m_pt2[m] = 1;
      if (m_s2[m] == WIN) m_over[m] = 1; else m_left[m] = rp_of(m);
    end else begin
      if (m_s1[m] < (1 << SW) - 1) m_s1[m]++;
      m_pt1[m] = 1;
      if (m_s1[m] == WIN) m_over[m] = 1; else m_left[m] = rp_of(m);
    end
  endtask

  task automatic model_step(input bit f, input int v, input bit obj,
                            input logic [1:0] pad, input bit rs);
    for (int m = 0; m < 2; m++) begin
      bit miss_a, miss_b;
      m_pt1[m] = 0;
      m_pt2[m] = 0;
      if (m_over[m]) begin
        if (rs) begin m_s1[m] = 0; m_s2[m] = 0; m_over[m] = 0; m_wait[m] = 1; end
      end else if (m_left[m] > 0) begin
        if (f) begin
          m_left[m]--;
          if (m_left[m] == 0) m_wait[m] = 1;
        end
      end else if (m_wait[m]) begin
        if (f) begin
          m_wait[m] = 0;
          for (int s = 0; s < 2; s++) begin m_hit[m][s] = 0; m_pass[m][s] = 0; end
          model_pixel(m, v, obj, pad);
        end
      end else if (f) begin
        miss_a = m_pass[m][0] && !m_hit[m][0];
        miss_b = m_pass[m][1] && !m_hit[m][1];
        for (int s = 0; s < 2; s++) begin m_hit[m][s] = 0; m_pass[m][s] = 0; end
        if (m == 0 && miss_a && !miss_b)      model_score(m, 0);
        else if (m == 0 && miss_b && !miss_a) model_score(m, 1);
        else if (miss_a || miss_b)            m_left[m] = rp_of(m);
        else                                  model_pixel(m, v, obj, pad);
      end else begin
        model_pixel(m, v, obj, pad);
      end
    end
  endtask

  task automatic chk(input string tag, input int m, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] @%0t: observed %0d, expected %0d", tag, m, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      bit ov;
      int pc;
      ov = m_over[m] || (m_left[m] > 0);
      pc = (m_left[m] > 0) ? rp_of(m) - m_left[m] : 0;
      chk("obj_rst",    m, 32'(obj_rst_o[m]),    32'(ov));
      chk("game_over",  m, 32'(game_over_o[m]),  32'(ov));
      chk("match_over", m, 32'(match_over_o[m]), 32'(m_over[m]));
      chk("score_p1",   m, 32'(score_p1_o[m]),   32'(m_s1[m]));
      chk("score_p2",   m, 32'(score_p2_o[m]),   32'(m_s2[m]));
      chk("point_p1",   m, 32'(point_p1_o[m]),   32'(m_pt1[m]));
      chk("point_p2",   m, 32'(point_p2_o[m]),   32'(m_pt2[m]));
      chk("pause_cnt",  m, 32'(pause_cnt_o[m]),  32'(pc));
    end
  endtask

  // One pixel cycle: apply inputs, clock, advance model, check just after the edge.
  task automatic tick(input bit f, input int v, input bit obj, input logic [1:0] pad);
    fsync = f;
    vpos = v[11:0];
    active_obj = obj;
    active_paddle = pad;
    @(posedge pixel_clk);
    model_step(f, v, obj, pad, restart);
    #1 check_all();
  endtask

  // Directed frame: harmless filler, optional ball on each guard row, then fsync.
  task automatic frame(input bit b1, input logic [1:0] pad1, input bit b2, input logic [1:0] pad2);
    int n = int'($urandom_range(1, 3));
    for (int i = 0; i < n; i++)
      tick(1'b0, filler_v(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    if (b1) tick(1'b0, ROW_BOT, 1'b1, pad1);
    if (b2) tick(1'b0, ROW_TOP, 1'b1, pad2);
    tick(1'b1, filler_v(), 1'b0, 2'b00);
  endtask

  // Random frame, guard rows favoured, fsync may coincide with a guard pixel.
  task automatic rframe();
    int n = int'($urandom_range(0, 4));
    restart = ($urandom_range(0, 7) == 0);
    for (int i = 0; i < n; i++)
      tick(1'b0, rand_v(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    tick(1'b1, rand_v(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge pixel_clk);
    #1 check_all();
    rst_n = 1'b1;

    // Enter SCAN, then clean hits; restart held high in SCAN must do nothing.
    frame(0, 2'b00, 0, 2'b00);
    restart = 1'b1;
    frame(1, 2'b01, 0, 2'b00);
    frame(1, 2'b11, 1, 2'b10);
    chk("scan_game_over", 0, 32'(game_over_o[0]), 32'(0));

    // P1 misses: P2 scores, 128-frame overlay; restart still held and ignored.
    frame(1, 2'b00, 0, 2'b00);
    chk("miss_score_p2", 0, 32'(score_p2_o[0]), 32'(1));
    repeat (RP_TS) frame(0, 2'b00, 0, 2'b00);
    restart = 1'b0;
    chk("pause_end_game_over", 0, 32'(game_over_o[0]), 32'(0));

    // Miss pixel while waiting is ignored; fsync enters SCAN.
    frame(1, 2'b00, 0, 2'b00);

    // P2 misses seven times: P1 reaches the winning score.
    for (int k = 0; k < WIN; k++) begin
      frame(0, 2'b00, 1, 2'b01);
      if (k < WIN - 1) repeat (RP_TS + 1) frame(0, 2'b00, 0, 2'b00);
    end
    chk("win_score_p1", 0, 32'(score_p1_o[0]), 32'(WIN));
    chk("win_match_over", 0, 32'(match_over_o[0]), 32'(1));
    frame(1, 2'b00, 1, 2'b00);
    restart = 1'b1;
    tick(1'b0, filler_v(), 1'b0, 2'b00);
    restart = 1'b0;
    chk("restart_score_p1", 0, 32'(score_p1_o[0]), 32'(0));
    chk("restart_match_over", 0, 32'(match_over_o[0]), 32'(0));

    // Single-sided: P2 paddle saves the bottom row, then a miss pauses without points.
    frame(0, 2'b00, 0, 2'b00);
    frame(1, 2'b10, 0, 2'b00);
    frame(1, 2'b00, 0, 2'b00);
    chk("ss_game_over", 1, 32'(game_over_o[1]), 32'(1));
    repeat (RP_TS + 1) frame(0, 2'b00, 0, 2'b00);

    // Asynchronous reset in the middle of a pause.
    frame(1, 2'b00, 0, 2'b00);
    repeat (50) frame(0, 2'b00, 0, 2'b00);
    chk("pause_cnt_50", 0, 32'(pause_cnt_o[0]), 32'(50));
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge pixel_clk);
    #1 rst_n = 1'b1;
    check_all();
    frame(1, 2'b00, 0, 2'b00);
    frame(0, 2'b00, 0, 2'b00);

    // Randomised play.
    repeat (600) rframe();
    restart = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pong_referee.md
Name: pong_referee

Overview:
- Parametrised successor to the top-level game-over detector: per-frame hit/miss judging for two paddles, per-player scoring, match win, restart pause.
- Sits between the object/paddle pixel generators and the pixel mux, clocked on pixel_clk.
- Drives the object/paddle reset and the game-over overlay enable.
- Supports a single-sided (both paddles defend bottom) and a two-sided (P1 bottom, P2 top) mode.

Parameters:
- VRES, 720, active lines per frame
- PADDLE_H, 20, paddle height in lines
- TWO_SIDED, 1, 0 = both paddles guard bottom row; 1 = P1 guards row VRES-PADDLE_H, P2 guards row PADDLE_H-1
- RESTART_PAUSE, 128, frames the game-over overlay is held after a miss (1..2^PAUSE_W-1)
- PAUSE_W, 8, pause counter width
- WIN_SCORE, 7, points that end a match (TWO_SIDED=1 only)
- SCORE_W, 4, score counter width; WIN_SCORE < 2^SCORE_W

Ports:
- pixel_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous assert, active-low
- fsync  in  1  one-cycle frame-start pulse
- vpos  in  12 (signed)  current line
- active_obj  in  1  ball covers current pixel
- active_paddle  in  2  bit0 = P1 paddle covers pixel, bit1 = P2
- restart  in  1  level; starts a new match from MATCH_OVER
- obj_rst  out  1  hold ball/paddles in reset; high during PAUSE and MATCH_OVER
- game_over  out  1  overlay enable; high during PAUSE and MATCH_OVER
- match_over  out  1  high in MATCH_OVER
- score_p1, score_p2  out  SCORE_W  points
- point_p1, point_p2  out  1  one-cycle pulse when that player scores
- pause_cnt  out  PAUSE_W  frames elapsed in PAUSE

Behaviour:
- Reset (rst_n low, any state, asynchronous): state WAIT. All outputs 0. Per-frame flags hit[1:0] and pass[1:0] cleared.
- Guard row of side s:
  - TWO_SIDED=1: row_p1 = VRES-PADDLE_H, row_p2 = PADDLE_H-1.
  - TWO_SIDED=0: both sides use VRES-PADDLE_H, and a hit by either paddle counts as a hit for both sides.
- WAIT: on fsync, go to SCAN and clear hit/pass.
- SCAN, each cycle, for each side s with vpos == row_s && active_obj:
  - active_paddle[s] (or either bit when TWO_SIDED=0) sets hit[s];
  - otherwise sets pass[s].
- SCAN, on the next fsync, judge the frame:
  - miss[s] = pass[s] && !hit[s].
  - No miss: clear flags, stay in SCAN. The fsync also starts the next frame, so there is no WAIT detour.
  - Miss on side s, TWO_SIDED=1: the opponent's score increments, with a one-cycle point pulse registered on the judging fsync and visible the following cycle. If the new score == WIN_SCORE, go to MATCH_OVER; else go to PAUSE.
  - Simultaneous miss on both sides (degenerate geometry): no point is awarded; go to PAUSE.
  - TWO_SIDED=0: a miss awards no point; go to PAUSE; a match never ends.
- PAUSE:
  - obj_rst = game_over = 1.
  - Each fsync: if pause_cnt == RESTART_PAUSE-1, clear pause_cnt, clear obj_rst and game_over, go to WAIT. Otherwise pause_cnt+1.
  - The overlay therefore lasts exactly RESTART_PAUSE frames.
- MATCH_OVER:
  - obj_rst = game_over = match_over = 1.
  - Scores frozen.
  - restart sampled high: both scores ← 0, all outputs ← 0, go to WAIT.
  - restart is ignored in all other states.
- Scores saturate at 2^SCORE_W-1. They are never wrapped.
- Register updates take effect one cycle after the triggering input.
- Registered outputs: obj_rst, game_over, match_over, point_p1, point_p2, score_p1, score_p2, pause_cnt.
- fsync arriving in the same cycle as a guard-row pixel: the judgement uses the flags as they stood before that cycle; the pixel is counted toward the new frame.

Test Plan:
- Ball on row 700 with active_paddle=01, TWO_SIDED=1 → at next fsync no miss; state stays SCAN; scores 0/0; game_over=0.
- Ball on row 700, no paddle, TWO_SIDED=1 → next fsync: point_p2 pulses once; score_p2=1; obj_rst=game_over=1; after exactly 128 further fsyncs game_over=0 and state is WAIT.
- Ball on row 19, no paddle, 7 times in succession (WIN_SCORE=7) → score_p1=7, match_over=1. A further missed frame changes nothing. restart=1 → scores 0/0, all outputs 0.
- TWO_SIDED=0: ball on row 700, paddle bit1 only → counted as hit. Same row with no paddle → PAUSE with scores still 0/0.
- rst_n pulled low mid-PAUSE at pause_cnt=50 → outputs 0 immediately without waiting for a clock edge. After release: WAIT, pause_cnt=0.
- restart held high while in SCAN and PAUSE → no effect; scores unchanged.
